// File: rtl/equiv_pkg.sv
// Shared types and default widths for the equivalence miter sequencer.
package equiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N_IN  = 5;
    localparam int DEF_N_OUT = 1;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/equiv_miter_seq_if.sv
// Control, status and netlist-facing signals of the miter sequencer.
interface equiv_miter_seq_if
    import equiv_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             stop_on_fail;
    logic [N_IN-1:0]  vec;
    logic [N_OUT-1:0] dut_a_o;
    logic [N_OUT-1:0] dut_b_o;
    logic             busy;
    logic             done;
    logic             equiv;
    logic [N_IN-1:0]  fail_vec;
    logic [CNT_W-1:0] mism_cnt;

    // Environment side: issues commands and returns the netlist responses.
    modport master (
        output start, stop_on_fail, dut_a_o, dut_b_o,
        input  vec, busy, done, equiv, fail_vec, mism_cnt
    );

    // Sequencer side.
    modport slave (
        input  start, stop_on_fail, dut_a_o, dut_b_o,
        output vec, busy, done, equiv, fail_vec, mism_cnt
    );
endinterface

// File: rtl/miter_cmp.sv
// Bitwise output comparator with a saturating mismatch counter.
module miter_cmp
    import equiv_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] a,
    input  logic [N_OUT-1:0] b,
    output logic             mism,
    output logic [CNT_W-1:0] cnt
);
    assign mism = |(a ^ b);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && mism && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/equiv_miter_seq.sv
// Exhaustive vector sweeper feeding two combinational netlists, with a miter
// that reports equivalence, the first failing vector and a mismatch count.
module equiv_miter_seq
    import equiv_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    equiv_miter_seq_if.slave bus
);
    state_t           state;
    logic [N_IN-1:0]  vec_q;
    logic [N_IN-1:0]  fail_vec_q;
    logic             fail_seen;
    logic             stop_q;
    logic             busy_q;
    logic             done_q;
    logic             mism;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             run_en;
    logic             last_vec;

    assign accept   = bus.start && (state != RUN);
    assign run_en   = (state == RUN);
    assign last_vec = (vec_q == '1);

    miter_cmp #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) u_cmp (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (run_en),
        .a    (bus.dut_a_o),
        .b    (bus.dut_b_o),
        .mism (mism),
        .cnt  (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec_q      <= '0;
            fail_vec_q <= '0;
            fail_seen  <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state      <= RUN;
                        vec_q      <= '0;
                        fail_vec_q <= '0;
                        fail_seen  <= 1'b0;
                        stop_q     <= bus.stop_on_fail;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                RUN: begin
                    if (mism && !fail_seen) begin
                        fail_vec_q <= vec_q;
                        fail_seen  <= 1'b1;
                    end
                    // The last vector is compared in the same cycle it ends the sweep, so vec never wraps.
                    if (last_vec || (mism && stop_q)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        vec_q <= vec_q + N_IN'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec      = vec_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.equiv    = done_q && (cnt == '0);
    assign bus.fail_vec = fail_vec_q;
    assign bus.mism_cnt = cnt;
endmodule
